// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative RV32M multiply/divide execute unit
module ex_mdu #(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] res_o,
   output logic [4:0]      rd_o,
   output logic            busy_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BPC - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [XLEN-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
   logic [XLEN-1:0] hi_q, hi_d;     // product high half or partial remainder
   logic [XLEN-1:0] lo_q, lo_d;     // remaining multiplier or dividend/quotient shifter
   logic            neg_q, neg_d;   // final result must be negated
   logic [CW-1:0]   cnt_q, cnt_d;

   // accept-time decode of operand signedness, magnitudes and special cases
   logic            accept;
   logic            sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf;

   assign accept   = valid_i & (state_q == S_IDLE) & ~flush_i;
   assign sgn_a    = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
   assign sgn_b    = op_i[2] ? ~op_i[0] : ~op_i[1];
   assign neg_a    = sgn_a & rs1_i[XLEN-1];
   assign neg_b    = sgn_b & rs2_i[XLEN-1];
   assign mag_a    = neg_a ? -rs1_i : rs1_i;
   assign mag_b    = neg_b ? -rs2_i : rs2_i;
   assign div_zero = (rs2_i == '0);
   assign div_ovf  = ~op_i[0] & (rs1_i == INT_MIN) & (&rs2_i);

   // multiply step: add digit * multiplicand into the high half, shift right by one digit
   logic [XLEN+MUL_BPC-1:0] mul_part, mul_sum;
   logic [2*XLEN-1:0]       prod_nx, prod_fix;

   assign mul_part = {{MUL_BPC{1'b0}}, opa_q} * {{XLEN{1'b0}}, lo_q[MUL_BPC-1:0]};
   assign mul_sum  = {{MUL_BPC{1'b0}}, hi_q} + mul_part;
   assign prod_nx  = {mul_sum, lo_q[XLEN-1:MUL_BPC]};
   assign prod_fix = neg_q ? -prod_nx : prod_nx;

   // restoring divide step: shift in next dividend bit, subtract divisor if it fits
   logic [XLEN:0]   div_sh, div_diff;
   logic            div_ge;
   logic [XLEN-1:0] quo_nx, rem_nx;

   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opa_q};
   assign div_ge   = ~div_diff[XLEN];
   assign rem_nx   = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
   assign quo_nx   = {lo_q[XLEN-2:0], div_ge};

   // next-state and datapath control; flush overrides every state
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      res_d   = res_q;
      opa_d   = opa_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = op_i;
               rd_d  = rd_i;
               cnt_d = '0;
               hi_d  = '0;
               if (!op_i[2]) begin
                  state_d = S_MUL;
                  opa_d   = mag_a;
                  lo_d    = mag_b;
                  neg_d   = neg_a ^ neg_b;
               end else if (div_zero) begin
                  state_d = S_DONE;
                  res_d   = op_i[1] ? rs1_i : '1;
               end else if (div_ovf) begin
                  state_d = S_DONE;
                  res_d   = op_i[1] ? '0 : rs1_i;
               end else begin
                  state_d = S_DIV;
                  opa_d   = mag_b;
                  lo_d    = mag_a;
                  neg_d   = op_i[1] ? neg_a : (neg_a ^ neg_b);
               end
            end
         end
         S_MUL: begin
            hi_d  = prod_nx[2*XLEN-1:XLEN];
            lo_d  = prod_nx[XLEN-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == MUL_LAST) begin
               state_d = S_DONE;
               res_d   = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            end
         end
         S_DIV: begin
            hi_d  = rem_nx;
            lo_d  = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DIV_LAST) begin
               state_d = S_DONE;
               if (op_q[1]) res_d = neg_q ? -rem_nx : rem_nx;
               else         res_d = neg_q ? -quo_nx : quo_nx;
            end
         end
         S_DONE: begin
            if (ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) state_d = S_IDLE;
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         opa_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         opa_q   <= opa_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o = (state_q == S_IDLE);
   assign valid_o = (state_q == S_DONE);
   assign busy_o  = (state_q != S_IDLE);
   assign res_o   = res_q;
   assign rd_o    = rd_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed and model-checked bench for ex_mdu
module tb_ex_mdu;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
   logic [2:0]  op_i;
   logic [31:0] rs1_i, rs2_i, res_o;
   logic [4:0]  rd_i, rd_o;

   int n_checks = 0;
   int n_fail   = 0;

   ex_mdu #(.XLEN(32), .MUL_BPC(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .rd_o(rd_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'b000: begin p = sa * sb; return p[31:0];  end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'b101: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = ua / ub; return p[31:0];
         end
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   // issue one op, measure latency, hold the result for 'hold' cycles, then hand it off
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
      int lat;
      @(negedge clk_i);
      valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
      lat = 0;
      do begin
         @(posedge clk_i); #1;
         valid_i = 1'b0; op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
         lat++;
      end while (!valid_o && lat < 200);
      check_eq({tag, " valid"}, 32'(valid_o), 32'd1);
      check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i); #1;
         check_eq({tag, " held res"}, res_o, exp_res);
         check_eq({tag, " held flags"}, 32'({valid_o, ready_o, busy_o}), 32'b101);
      end
      check_eq({tag, " res"}, res_o, exp_res);
      check_eq({tag, " rd"}, 32'(rd_o), 32'(rd));
      @(negedge clk_i); ready_i = 1'b1;
      @(posedge clk_i); #1; ready_i = 1'b0;
      check_eq({tag, " idle after handshake"}, 32'({valid_o, ready_o, busy_o}), 32'b010);
   endtask

   initial begin
      int seen;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          rlat;

      rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
      op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("reset flags", 32'({valid_o, ready_o, busy_o}), 32'b010);
      check_eq("reset res", res_o, 32'd0);
      check_eq("reset rd", 32'(rd_o), 32'd0);
      @(negedge clk_i); rst_ni = 1'b1;

      run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 17, 0);
      run_op("MULH -1*-1",      3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'h00000000, 17, 0);
      run_op("MULHU max^2",     3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 17, 0);
      run_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 17, 0);
      run_op("MUL min*min",     3'b000, 32'h80000000,   32'h80000000, 5'd9,  32'h00000000, 17, 0);
      run_op("MULH min*min",    3'b001, 32'h80000000,   32'h80000000, 5'd10, 32'h40000000, 17, 0);
      run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFD, 33, 0);
      run_op("REM -7%2",        3'b110, 32'hFFFFFFF9,   32'd2,        5'd12, 32'hFFFFFFFF, 33, 0);
      run_op("DIVU 100/7",      3'b101, 32'd100,        32'd7,        5'd13, 32'd14,       33, 0);
      run_op("REMU 100%7",      3'b111, 32'd100,        32'd7,        5'd14, 32'd2,        33, 0);
      run_op("DIVU min/max",    3'b101, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'd0,        33, 0);
      run_op("DIV x/0",         3'b100, 32'd1234,       32'd0,        5'd16, 32'hFFFFFFFF, 1,  0);
      run_op("REMU 5%0",        3'b111, 32'd5,          32'd0,        5'd17, 32'd5,        1,  0);
      run_op("DIV ovf",         3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd18, 32'h80000000, 1,  0);
      run_op("REM ovf",         3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd19, 32'd0,        1,  0);
      run_op("backpressure",    3'b000, 32'd3,          32'd5,        5'd20, 32'd15,       17, 10);
      run_op("after bp",        3'b101, 32'd9,          32'd3,        5'd21, 32'd3,        33, 0);

      // flush in the fifth DIV cycle
      @(negedge clk_i); valid_i = 1'b1; op_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd3;
      @(posedge clk_i); #1; valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      @(negedge clk_i); flush_i = 1'b1;
      @(posedge clk_i); #1; flush_i = 1'b0;
      check_eq("flush mid-DIV flags", 32'({valid_o, ready_o, busy_o}), 32'b010);
      seen = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1;
      end
      check_eq("flush no result", 32'(seen), 32'd0);

      // flush in IDLE blocks acceptance
      @(negedge clk_i); valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2;
      @(posedge clk_i); #1; valid_i = 1'b0; flush_i = 1'b0;
      check_eq("flush idle blocks", 32'({valid_o, ready_o, busy_o}), 32'b010);

      // asynchronous reset in the middle of a multiply
      @(negedge clk_i); valid_i = 1'b1; op_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd9; rd_i = 5'd9;
      @(posedge clk_i); #1; valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      check_eq("mid-MUL busy", 32'(busy_o), 32'd1);
      @(negedge clk_i); #1; rst_ni = 1'b0; #1;
      check_eq("async reset flags", 32'({valid_o, ready_o, busy_o}), 32'b010);
      check_eq("async reset res", res_o, 32'd0);
      check_eq("async reset rd", 32'(rd_o), 32'd0);
      @(negedge clk_i); rst_ni = 1'b1;
      run_op("after reset", 3'b001, 32'h00010000, 32'h00010000, 5'd22, 32'd1, 17, 0);

      // model-checked operations with random backpressure
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom);
         ra  = pick();
         rb  = pick();
         if (!rop[2]) rlat = 17;
         else if (rb == 0 || (!rop[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF)) rlat = 1;
         else rlat = 33;
         run_op($sformatf("rnd%0d op%0d a=%08h b=%08h", i, rop, ra, rb), rop, ra, rb, 5'($urandom),
                ref_mdu(rop, ra, rb), rlat, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
